// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: sequential word fetches over req/ack into a small FIFO
// feeding IF/ID. Optional same-cycle bypass of returned data when the FIFO is empty: FETCH_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     o_valid,
    output logic [31:0]              o_instruction,
    output logic [31:0]              o_pc_plus_4,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] instr;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            imem_req_q, imem_req_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];

    logic            ack_fire;
    logic            outstanding;
    logic            has_credit;
    logic            fifo_empty;
    logic            bypass_hit;
    logic            push;
    logic            pop;
    logic            pop_fifo;
    logic [31:0]     addr_plus_4;
    logic [31:0]     redirect_target;
    entry_t          head;

    assign ack_fire        = imem_req_q & imem_ack;
    assign outstanding     = (state_q != RUN);
    assign addr_plus_4     = imem_addr_q + 32'd4;
    assign redirect_target = redirect_pc & ~32'h3;
    assign fifo_empty      = (count_q == '0);
    // Credit counts the in-flight request so a returning word always has a free slot.
    assign has_credit      = (count_q + CW'(outstanding)) < CW'(DEPTH);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = fifo_empty & (state_q == WAIT) & ack_fire & ~redirect;
`else
    assign bypass_hit = 1'b0;
`endif

    assign o_valid  = ~fifo_empty | bypass_hit;
    assign pop      = o_valid & ~stall & ~redirect;
    assign pop_fifo = pop & ~fifo_empty;
    // A bypassed word consumed this cycle never enters the FIFO.
    assign push     = (state_q == WAIT) & ack_fire & ~redirect & ~(bypass_hit & ~stall);

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (bypass_hit) begin
            head = '{pc_plus_4: addr_plus_4, instr: imem_rdata};
        end else if (fifo_empty) begin
            head = '0;
        end
    end

    assign o_instruction = head.instr;
    assign o_pc_plus_4   = head.pc_plus_4;
    assign o_count       = count_q;
    assign imem_req      = imem_req_q;
    assign imem_addr     = imem_addr_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (has_credit) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (ack_fire) begin
                    imem_req_d = 1'b0;
                    state_d    = RUN;
                    fetch_pc_d = redirect ? redirect_target : addr_plus_4;
                end else if (redirect) begin
                    fetch_pc_d = redirect_target;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The stale request must still complete; its data is dropped.
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (ack_fire) begin
                    imem_req_d = 1'b0;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_fifo);
            wr_ptr_d = wr_ptr_q + PW'(push);
            count_d  = count_q + CW'(push) - CW'(pop_fifo);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so all registers update together at the edge.
        if (!rst) begin
            state_q     <= RUN;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc_plus_4: addr_plus_4, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: a transaction-level model predicts fetch addresses
// and the in-order instruction stream; a negedge monitor compares every cycle.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          o_valid;
    logic [31:0]   o_instruction;
    logic [31:0]   o_pc_plus_4;
    logic [CW-1:0] o_count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc_plus_4   (o_pc_plus_4),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Reference model state (post-edge view)
    entry_t      exp_q[$];
    bit          out_live = 0;
    bit          out_drop = 0;
    logic [31:0] out_addr = RESET_PC;
    logic [31:0] exp_addr = RESET_PC;
    bit          popped = 0;
    bit          bypass_taken = 0;
    bit          saw_wrap = 0;
    int          occ;

    // Model advances at each edge using the inputs that were stable during the cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            out_live = 0;
            out_drop = 0;
            out_addr = RESET_PC;
            exp_addr = RESET_PC;
            popped = 0;
            bypass_taken = 0;
        end else begin
            occ = exp_q.size() + (popped ? 1 : 0);
            if (out_live) begin
                if (imem_ack) begin
                    if (!out_drop && !redirect) begin
                        if (!bypass_taken) exp_q.push_back('{pc4: out_addr + 32'd4, instr: mem_word(out_addr)});
                        exp_addr = out_addr + 32'd4;
                    end
                    out_live = 0;
                    out_drop = 0;
                end else if (redirect) begin
                    out_drop = 1;
                end
            end else if (!redirect && occ < DEPTH) begin
                out_live = 1;
                out_addr = exp_addr;
            end
            if (redirect) begin
                exp_q.delete();
                exp_addr = {redirect_pc[31:2], 2'b00};
            end
            popped = 0;
            bypass_taken = 0;
        end
    end

    entry_t mon_head;
    bit     mon_valid;
    bit     mon_byp;

    always @(negedge clk) begin
        if (rst) begin
            mon_valid = (exp_q.size() != 0);
            mon_head  = mon_valid ? exp_q[0] : '0;
            mon_byp   = 0;
`ifdef FETCH_BYPASS_EN
            if (!mon_valid && out_live && !out_drop && imem_ack && !redirect) begin
                mon_valid = 1;
                mon_byp   = 1;
                mon_head  = '{pc4: out_addr + 32'd4, instr: mem_word(out_addr)};
            end
`endif
            check("o_valid", 32'(o_valid), 32'(mon_valid));
            check("o_count", 32'(o_count), 32'(exp_q.size()));
            check("o_instruction", o_instruction, mon_head.instr);
            check("o_pc_plus_4", o_pc_plus_4, mon_head.pc4);
            check("imem_req", 32'(imem_req), 32'(out_live));
            if (out_live) check("imem_addr", imem_addr, out_addr);
            if (mon_valid && mon_head.pc4 == 32'h0) saw_wrap = 1;
            if (mon_valid && !stall && !redirect) begin
                if (mon_byp) bypass_taken = 1;
                else begin
                    void'(exp_q.pop_front());
                    popped = 1;
                end
            end
        end
    end

    // Instruction memory responder with per-request random latency.
    int max_lat = 0;
    int cur_lat = 0;
    int wait_cnt = 0;

    task automatic drive_mem();
        if (imem_req) begin
            imem_ack = (wait_cnt >= cur_lat);
            wait_cnt++;
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
            cur_lat  = $urandom_range(0, max_lat);
        end
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    endtask

    task automatic drive(input bit st, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        drive_mem();
    endtask

    task automatic run_rand(input int cycles, input int stall_pct, input int redir_pct);
        logic [31:0] rpc;
        for (int i = 0; i < cycles; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                1:       rpc = RESET_PC + 32'($urandom_range(0, 255));
                default: rpc = $urandom;
            endcase
            drive($urandom_range(0, 99) < stall_pct, $urandom_range(0, 99) < redir_pct, rpc);
        end
    endtask

    initial begin
        bit found;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_o_count", 32'(o_count), 32'h0);
        check("rst_o_instruction", o_instruction, 32'h0);
        check("rst_o_pc_plus_4", o_pc_plus_4, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        max_lat = 0;
        run_rand(40, 0, 0);

        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, '0);
        @(negedge clk);
        check("full_o_count", 32'(o_count), 32'(DEPTH));
        check("full_imem_req", 32'(imem_req), 32'h0);
        run_rand(12, 0, 0);

        max_lat = 3;
        run_rand(1500, 30, 5);

        max_lat = 1;
        drive(1'b0, 1'b1, 32'hFFFF_FFFE);
        saw_wrap = 0;
        run_rand(16, 0, 0);
        check("wrap_seen", 32'(saw_wrap), 32'h1);

        max_lat = 6;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            drive(1'b1, 1'b0, '0);
            if (imem_req && !imem_ack) found = 1;
        end
        check("mid_wait_found", 32'(found), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_imem_req", 32'(imem_req), 32'h0);
        check("async_o_valid", 32'(o_valid), 32'h0);
        check("async_o_count", 32'(o_count), 32'h0);
        check("async_imem_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1 rst = 1'b1;
        max_lat = 2;
        run_rand(300, 20, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Replaces the direct PC to instruction-memory path with a decoupled fetcher.
- Issues sequential word fetches over a req/ack handshake to a variable-latency instruction memory and buffers the returned instructions in a small FIFO.
- Presents one instruction with its PC+4 per cycle to IF/ID, and honours stall (hazard unit) and redirect (branch/jump resolved in ID).

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, at least 2).
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  IF/ID hold; no pop while high.
- redirect  in  1  taken branch/jump; flush the queue and refetch.
- redirect_pc  in  32  new fetch address, sampled when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address of the request.
- imem_ack  in  1  request accepted and imem_rdata valid this cycle.
- imem_rdata  in  32  instruction returned.
- o_valid  out  1  o_instruction/o_pc_plus_4 are valid.
- o_instruction  out  32  head instruction; 32'h0 (nop) when o_valid=0.
- o_pc_plus_4  out  32  head address + 4; 32'h0 when o_valid=0.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (async on rst=0):
  - fetch_pc=RESET_PC, FIFO empty, o_count=0.
  - imem_req=0, imem_addr=RESET_PC, o_valid=0, outputs 0.
  - FSM=RUN.
- Each FIFO entry holds {addr+4, instruction}. Pointers wrap modulo DEPTH. Occupancy is a separate counter from 0 to DEPTH.
- At most one outstanding request.
- Credit rule: a request issues only if o_count + (outstanding ? 1 : 0) < DEPTH. A pop in the same cycle does not create credit until the next cycle.
- Handshake:
  - imem_req and imem_addr are registered.
  - Once imem_req=1, imem_req and imem_addr stay stable until a cycle with imem_ack=1.
  - A transfer completes on imem_req & imem_ack at the clock edge.
  - imem_req may reassert in the cycle after an ack.
  - With back-to-back acks and free credit, throughput is one fetch per 2 cycles.
- FSM states:
  - RUN: no request outstanding. Issue a request at fetch_pc if credit allows, then go to WAIT.
  - WAIT: on ack, push {imem_addr+4, imem_rdata}, set fetch_pc=imem_addr+4, drop imem_req, go to RUN.
  - DRAIN: a redirect arrived while a request was outstanding. Keep imem_req/imem_addr stable. On ack, discard the data (no push), drop imem_req, go to RUN with fetch_pc already equal to the redirect target.
- Pop: on o_valid & ~stall & ~redirect at the edge, advance the read pointer and decrement the count.
- Push and pop in the same cycle leave o_count unchanged. A push into a full FIFO cannot occur (guaranteed by the credit rule).
- Redirect (priority over pop, push and stall):
  - Empty the FIFO; o_valid=0 the next cycle.
  - Set fetch_pc=redirect_pc.
  - In WAIT without ack: go to DRAIN. Any further redirect while in DRAIN only updates fetch_pc.
  - In WAIT with ack in the same cycle: discard the data, go to RUN.
  - In RUN: go to RUN. The new request issues the next cycle.
- redirect_pc[1:0] are forced to 0. Addresses wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Stall freezes the outputs but does not stop fetching while credit remains.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- When defined: if the FIFO is empty and an ack arrives (WAIT, no redirect), o_valid=1 in the same cycle with o_instruction=imem_rdata and o_pc_plus_4=imem_addr+4.
  - If stall=0, the entry is consumed without being pushed.
  - If stall=1, it is pushed normally.
- When undefined: returned data is visible no earlier than the cycle after the ack.

Test Plan:
- Release reset, imem_ack asserted one cycle after each request, stall=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008; o_pc_plus_4 follows 0x3004, 0x3008, ...; o_valid never shows a stale entry.
- stall=1 for 12 cycles with 1-cycle ack latency -> o_count saturates at 4, imem_req stays 0 while full; release stall -> 4 consecutive pops, in order.
- Request at 0x3010 outstanding with 3-cycle ack latency; redirect=1, redirect_pc=0x3100 on cycle 1 -> imem_addr holds 0x3010 until the ack, that data is not pushed, next request is 0x3100, o_valid=0 until 0x3100 returns.
- redirect in the same cycle as an ack and a pop with o_count=2 -> o_count=0 next cycle, returned data dropped, next imem_addr=redirect_pc.
- redirect_pc=32'hFFFF_FFFC -> first entry has o_pc_plus_4=0x0000_0000, next imem_addr=0x0.
- Assert rst=0 asynchronously mid-WAIT -> imem_req=0 and o_valid=0 immediately; after release, first imem_addr=0x3000. With FETCH_BYPASS_EN: empty FIFO plus ack with stall=0 -> o_valid=1 in the ack cycle, o_count stays 0.
